// File: rtl/prog_mem_loader.sv
// Writes an alternating ld/sd program and an index data pattern into memory, then releases the CPU.
// Optional feature: define LOADER_CHECKSUM_EN to XOR-accumulate every accepted instruction word.
module prog_mem_loader #(
  parameter int          INSTR_SIZE  = 32,
  parameter int          ADDR_W      = 5,
  parameter logic [4:0]  LOAD_REG    = 5'b00001,
  parameter logic [11:0] OFFSET_STEP = 12'd0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              wr_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [63:0]       dmem_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_run,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {IDLE, WR_IMEM, WR_DMEM, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(INSTR_SIZE - 1);

  state_t            state;
  logic [ADDR_W-1:0] index;
  logic [11:0]       offset;

  // Even slots hold ld at offset+4, odd slots hold sd at offset; funct3 011 selects doubleword.
  function automatic logic [31:0] encode(input logic odd, input logic [11:0] off);
    logic [11:0] imm;
    imm = off + 12'd4;
    if (!odd)
      encode = {imm, 5'd0, 3'b011, LOAD_REG, 7'b0000011};
    else
      encode = {off[11:5], LOAD_REG, 5'b11111, 3'b011, off[4:0], 7'b0100011};
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      index      <= '0;
      offset     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cpu_run    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= WR_IMEM;
            index      <= '0;
            offset     <= '0;
            imem_we    <= 1'b1;
            imem_addr  <= '0;
            imem_wdata <= encode(1'b0, 12'd0);
            busy       <= 1'b1;
            done       <= 1'b0;
            cpu_run    <= 1'b0;
          end
        end
        WR_IMEM: begin
          if (wr_ready) begin
            state      <= WR_DMEM;
            imem_we    <= 1'b0;
            dmem_we    <= 1'b1;
            dmem_addr  <= index;
            dmem_wdata <= 64'(index);
            if (index[0])
              offset <= offset + OFFSET_STEP;
          end
        end
        WR_DMEM: begin
          if (wr_ready) begin
            dmem_we <= 1'b0;
            if (index == LAST_IDX) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              cpu_run <= 1'b1;
            end else begin
              // Offset was already advanced on the sd accept, so the next word sees the new value.
              state      <= WR_IMEM;
              index      <= index + 1'b1;
              imem_we    <= 1'b1;
              imem_addr  <= index + 1'b1;
              imem_wdata <= encode(~index[0], offset);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Accumulates only on accepted instruction writes, so the value is naturally frozen in DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      checksum <= '0;
    else if ((state == IDLE || state == DONE) && start)
      checksum <= '0;
    else if (state == WR_IMEM && wr_ready)
      checksum <= checksum ^ imem_wdata;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: default build plus two small offset-step instances.
module tb_prog_mem_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n, start0, start1, start2, ready0, one;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rand_mode = 1'b0;

  logic        d0_iwe, d0_dwe, d0_busy, d0_done, d0_run;
  logic [4:0]  d0_iaddr, d0_daddr;
  logic [31:0] d0_idata, d0_csum;
  logic [63:0] d0_ddata;
  logic        d1_iwe, d1_dwe, d1_busy, d1_done, d1_run;
  logic [4:0]  d1_iaddr, d1_daddr;
  logic [31:0] d1_idata, d1_csum;
  logic [63:0] d1_ddata;
  logic        d2_iwe, d2_dwe, d2_busy, d2_done, d2_run;
  logic [4:0]  d2_iaddr, d2_daddr;
  logic [31:0] d2_idata, d2_csum;
  logic [63:0] d2_ddata;

  prog_mem_loader u_dut (
    .clock(clock), .reset_n(reset_n), .start(start0), .wr_ready(ready0),
    .imem_we(d0_iwe), .imem_addr(d0_iaddr), .imem_wdata(d0_idata),
    .dmem_we(d0_dwe), .dmem_addr(d0_daddr), .dmem_wdata(d0_ddata),
    .busy(d0_busy), .done(d0_done), .cpu_run(d0_run), .checksum(d0_csum));

  prog_mem_loader #(.INSTR_SIZE(4), .OFFSET_STEP(12'd8)) u_step8 (
    .clock(clock), .reset_n(reset_n), .start(start1), .wr_ready(one),
    .imem_we(d1_iwe), .imem_addr(d1_iaddr), .imem_wdata(d1_idata),
    .dmem_we(d1_dwe), .dmem_addr(d1_daddr), .dmem_wdata(d1_ddata),
    .busy(d1_busy), .done(d1_done), .cpu_run(d1_run), .checksum(d1_csum));

  prog_mem_loader #(.INSTR_SIZE(4), .OFFSET_STEP(12'd4095)) u_wrap (
    .clock(clock), .reset_n(reset_n), .start(start2), .wr_ready(one),
    .imem_we(d2_iwe), .imem_addr(d2_iaddr), .imem_wdata(d2_idata),
    .dmem_we(d2_dwe), .dmem_addr(d2_daddr), .dmem_wdata(d2_ddata),
    .busy(d2_busy), .done(d2_done), .cpu_run(d2_run), .checksum(d2_csum));

  logic [31:0] m0_imem [32];
  logic [63:0] m0_dmem [32];
  int          m0_icnt [32];
  int          m0_dcnt [32];
  logic [31:0] m1_imem [4];
  logic [31:0] m2_imem [4];
  int          excl_err = 0;
  int          stall_err = 0;
  int          stall_seen = 0;
  bit          pend = 1'b0;
  logic [108:0] pend_snap;

  always @(posedge clock) cyc <= cyc + 1;

  // wr_ready changes just after the rising edge, so the falling edge sees stable handshakes.
  always @(posedge clock) begin
    if (rand_mode) begin
      #2;
      ready0 = ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0;
    end
  end

  // Memory models record writes that the next rising edge will accept.
  always @(negedge clock) begin
    if (d0_iwe && d0_dwe) excl_err++;
    if (pend && pend_snap != {d0_iwe, d0_iaddr, d0_idata, d0_dwe, d0_daddr, d0_ddata}) stall_err++;
    pend = (d0_iwe || d0_dwe) && !ready0 && reset_n;
    if (pend) stall_seen++;
    pend_snap = {d0_iwe, d0_iaddr, d0_idata, d0_dwe, d0_daddr, d0_ddata};
    if (d0_iwe && ready0) begin
      m0_imem[d0_iaddr] = d0_idata;
      m0_icnt[d0_iaddr]++;
    end
    if (d0_dwe && ready0) begin
      m0_dmem[d0_daddr] = d0_ddata;
      m0_dcnt[d0_daddr]++;
    end
    if (d1_iwe) m1_imem[d1_iaddr[1:0]] = d1_idata;
    if (d2_iwe) m2_imem[d2_iaddr[1:0]] = d2_idata;
  end

  function automatic logic [31:0] ref_word(input int i, input logic [11:0] step);
    logic [11:0] off, imm;
    off = 12'((i / 2) * int'(step));
    imm = off + 12'd4;
    if (i % 2 == 0) ref_word = {imm, 5'd0, 3'b011, 5'd1, 7'b0000011};
    else            ref_word = {off[11:5], 5'd1, 5'd31, 3'b011, off[4:0], 7'b0100011};
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin
      m0_imem[i] = 'x;
      m0_dmem[i] = 'x;
      m0_icnt[i] = 0;
      m0_dcnt[i] = 0;
    end
  endtask

  task automatic apply_stimulus(input logic [2:0] mask, output int s_cyc);
    @(negedge clock);
    {start2, start1, start0} = mask;
    @(posedge clock);
    #1;
    {start2, start1, start0} = 3'b000;
    s_cyc = cyc;
  endtask

  task automatic wait_done0(input string name, input int bound);
    int k;
    k = 0;
    while (!d0_done && k < bound) begin
      @(posedge clock);
      #1;
      k++;
    end
    if (!d0_done) check_output({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic check_full_mem(input string name);
    int bad_data, bad_cnt;
    bad_data = 0;
    bad_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (m0_imem[i] !== ref_word(i, 12'd0) || m0_dmem[i] !== 64'(i)) bad_data++;
      if (m0_icnt[i] != 1 || m0_dcnt[i] != 1) bad_cnt++;
    end
    check_output({name, "_contents"}, 64'(bad_data), 64'd0);
    check_output({name, "_write_once"}, 64'(bad_cnt), 64'd0);
  endtask

  typedef struct {
    string       name;
    int          sel;
    int          addr;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [63:0] pick(input int sel, input int addr);
    case (sel)
      0:       pick = 64'(m0_imem[addr]);
      1:       pick = 64'(m1_imem[addr]);
      2:       pick = 64'(m2_imem[addr]);
      default: pick = m0_dmem[addr];
    endcase
  endfunction

  logic [31:0] exp_cs1, exp_cs2;

  initial begin
    int s_cyc;
    vecs[0]  = '{"imem0_ld",      0, 0,  64'h00403083};
    vecs[1]  = '{"imem1_sd",      0, 1,  64'h001FB023};
    vecs[2]  = '{"imem30_ld",     0, 30, 64'h00403083};
    vecs[3]  = '{"imem31_sd",     0, 31, 64'h001FB023};
    vecs[4]  = '{"dmem0",         3, 0,  64'd0};
    vecs[5]  = '{"dmem5",         3, 5,  64'd5};
    vecs[6]  = '{"dmem31",        3, 31, 64'd31};
    vecs[7]  = '{"step8_imem0",   1, 0,  64'h00403083};
    vecs[8]  = '{"step8_imem1",   1, 1,  64'h001FB023};
    vecs[9]  = '{"step8_imem2",   1, 2,  64'h00C03083};
    vecs[10] = '{"step8_imem3",   1, 3,  64'h001FB423};
    vecs[11] = '{"wrap_imem1",    2, 1,  64'h001FB023};
    vecs[12] = '{"wrap_imem2",    2, 2,  64'h00303083};
    vecs[13] = '{"wrap_imem3",    2, 3,  64'hFE1FBFA3};
`ifdef LOADER_CHECKSUM_EN
    exp_cs1 = 32'h00800400;
    exp_cs2 = 32'hFE700F80;
`else
    exp_cs1 = 32'h0;
    exp_cs2 = 32'h0;
`endif

    reset_n = 1'b0;
    {start2, start1, start0} = 3'b000;
    ready0 = 1'b1;
    one = 1'b1;
    clear_model();
    #7;
    check_output("reset_outputs", {d0_iwe, d0_dwe, d0_busy, d0_done, d0_run, d0_iaddr, d0_daddr},
                 64'd0);
    check_output("reset_data", {d0_idata, d0_csum} | d0_ddata, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    $display("[TB] run with wr_ready high");
    apply_stimulus(3'b111, s_cyc);
    check_output("busy_after_start", {d0_busy, d0_done, d0_iwe}, 64'b101);
    wait_done0("run1", 200);
    check_output("run1_done_latency", 64'(cyc - s_cyc), 64'd64);
    check_output("run1_done_flags", {d0_done, d0_run, d0_busy}, 64'b110);
    for (int i = 0; i < 14; i++)
      check_output(vecs[i].name, pick(vecs[i].sel, vecs[i].addr), vecs[i].exp);
    check_full_mem("run1");
    check_output("run1_checksum", 64'(d0_csum), 64'd0);
    check_output("step8_checksum", 64'(d1_csum), 64'(exp_cs1));
    check_output("wrap_checksum", 64'(d2_csum), 64'(exp_cs2));
    check_output("small_done", {d1_done, d1_run, d2_done, d2_run}, 64'b1111);

    $display("[TB] restart from DONE with random wr_ready");
    clear_model();
    rand_mode = 1'b1;
    apply_stimulus(3'b011, s_cyc);
    check_output("restart_drops_run", {d0_run, d0_done, d0_busy}, 64'b001);
    check_output("restart_clears_cs", 64'(d1_csum), 64'd0);
    wait_done0("run2", 2000);
    rand_mode = 1'b0;
    check_full_mem("run2");
    check_output("step8_cs_again", 64'(d1_csum), 64'(exp_cs1));

    $display("[TB] reset during load");
    @(negedge clock);
    ready0 = 1'b1;
    apply_stimulus(3'b001, s_cyc);
    begin
      int k;
      k = 0;
      while (!(d0_iwe && d0_iaddr == 5'd7) && k < 100) begin
        @(negedge clock);
        k++;
      end
      check_output("reached_index7", {d0_iwe, d0_iaddr}, {1'b1, 5'd7});
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_reset_ctl", {d0_iwe, d0_dwe, d0_busy, d0_done, d0_run, d0_iaddr, d0_daddr},
                 64'd0);
    check_output("async_reset_data", {d0_idata, d0_csum} | d0_ddata, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    clear_model();
    apply_stimulus(3'b001, s_cyc);
    repeat (5) @(posedge clock);
    begin
      int s_ignored;
      apply_stimulus(3'b001, s_ignored);
    end
    wait_done0("run3", 200);
    check_output("run3_done_latency", 64'(cyc - s_cyc), 64'd64);
    check_full_mem("run3");

    check_output("write_exclusive", 64'(excl_err), 64'd0);
    check_output("stall_stable", 64'(stall_err), 64'd0);
    check_output("stalls_exercised", 64'(stall_seen > 0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_mem_loader.md
# prog_mem_loader

Sequential initialiser directly upstream of the RISC-V CPU core. After reset and a start pulse it writes an alternating load/store (ld/sd) program into instruction memory and an index pattern into data memory through a ready-gated write port. It then releases the CPU by asserting `cpu_run`, replacing per-bench memory-initialisation loops with synthesisable, repeatable hardware.

## Interface
- `INSTR_SIZE`, default 32: number of instruction/data words written, ≥2.
- `ADDR_W`, default 5: address width, with 2**ADDR_W ≥ INSTR_SIZE.
- `LOAD_REG`, default 5'b00001: ld destination register and sd rs2.
- `OFFSET_STEP`, default 12'd0: amount added to the running offset after each sd.
- `clock` in, 1: sole clock, rising edge.
- `reset_n` in, 1: asynchronous, active-low reset.
- `start` in, 1: start request, sampled in IDLE and DONE.
- `wr_ready` in, 1: memory accepts the current write on any edge where it is high and a write enable is high.
- `imem_we` out, 1: instruction-memory write enable.
- `imem_addr` out, ADDR_W: instruction word index.
- `imem_wdata` out, 32: encoded instruction.
- `dmem_we` out, 1: data-memory write enable.
- `dmem_addr` out, ADDR_W: data word index.
- `dmem_wdata` out, 64: data word, equal to the zero-extended index.
- `busy` out, 1: high in WR_IMEM and WR_DMEM.
- `done` out, 1: high in DONE.
- `cpu_run` out, 1: CPU enable, equal to `done`.
- `checksum` out, 32: see Configuration.

## Operation
- All outputs are registered. The reset value of every output, the index counter, the offset and the FSM (→ IDLE) is 0.
- **States:** IDLE → WR_IMEM → WR_DMEM → (WR_IMEM | DONE).
  - IDLE: on `start`=1, go to WR_IMEM with index=0 and offset=0.
  - WR_IMEM: `imem_we`=1, `imem_addr`=index. Hold until `wr_ready`=1, then go to WR_DMEM.
  - WR_DMEM: `dmem_we`=1, `dmem_addr`=index, `dmem_wdata`=index. Hold until `wr_ready`=1. Then:
    - if index == INSTR_SIZE-1, go to DONE;
    - otherwise increment index and go to WR_IMEM.
  - DONE: `done`=`cpu_run`=1. `start`=1 restarts the sequence (→ WR_IMEM, index=0, offset=0) and drops `cpu_run` on the same edge.
- **Encoding.** Both instructions use funct3 3'b011.
  - Even index: ld, `imem_wdata` = {offset+4, 5'd0, 3'b011, LOAD_REG, 7'b0000011}.
  - Odd index: sd, `imem_wdata` = {offset[11:5], LOAD_REG, 5'b11111, 3'b011, offset[4:0], 7'b0100011}.
- **Offset arithmetic.** 12-bit, wraps modulo 4096 with no saturation; offset+4 also wraps. Offset += OFFSET_STEP when an sd word is accepted.
- **Write exclusivity.** `imem_we` and `dmem_we` are never high together. Address and data are stable while a write is pending (`we`=1, `wr_ready`=0).
- `start` while `busy` is ignored.

## Timing
- Writes complete on the edge where `we`=1 and `wr_ready`=1; the next state's outputs are valid after that edge.
- With `wr_ready` tied high, each word pair takes 2 cycles. `done` rises exactly 2·INSTR_SIZE edges after the edge that sampled `start`.
- `wr_ready` low stalls the FSM indefinitely with no timeout, and no write is lost or duplicated.
- Asserting `reset_n` mid-load immediately forces all outputs to 0 and returns the FSM to IDLE. Partial memory contents are not erased; a new `start` rewrites them.
- `start` held high in DONE restarts on every DONE entry; benches pulse it for one cycle.

## Configuration
- `LOADER_CHECKSUM_EN` defined: `checksum` is the XOR of every accepted `imem_wdata` since the last start. It is cleared on start and on reset, and frozen in DONE.
- Not defined: `checksum` is a constant 0 and no accumulator logic exists.

## Test plan
- **Default parameters, `wr_ready`=1, start pulse:**
  - imem[0]=0x00403083 (ld x1,4(x0));
  - imem[1]=0x001FB023 (sd x1,0(x31));
  - dmem[5]=5;
  - `done` and `cpu_run` high exactly 64 edges after start.
- **`wr_ready` toggled pseudo-randomly:** memory contents identical to the previous case; each address written exactly once; outputs stable during stalls.
- **OFFSET_STEP=12'd8, INSTR_SIZE=4:**
  - imem[2]=ld imm 12 = 0x00C03083;
  - imem[3]=sd imm 8 = 0x001FB423.
- **OFFSET_STEP=12'd4095:** offset wraps through 0xFFF with no X; imem[2] ld imm = 0x003.
- **`reset_n` low at index 7:** all outputs 0 asynchronously. A re-start completes the full 64-write sequence. `start` pulsed during `busy` has no effect.
- **With `LOADER_CHECKSUM_EN`:** `checksum` equals the XOR of all 32 expected words. In DONE, a start pulse clears it and drops `cpu_run` on the next edge.
